// File: rtl/lift_hall_dispatcher.sv
// Hall-call dispatcher: latches up/down hall requests per floor and hands
// each one to the cheapest in-service car through a valid/ready offer.
// Requests clear when any car serves them; assigned requests that go stale
// (timeout or car out of service) fall back to pending and are re-offered.
module lift_hall_dispatcher #(
   parameter int N_FLOORS = 12,
   parameter int N_LIFTS  = 3,
   parameter int TIMEOUT  = 64,
   parameter int FLR_W    = $clog2(N_FLOORS),
   parameter int LIFT_W   = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_FLOORS-1:0]        up_rqst,
   input  logic [N_FLOORS-1:0]        dn_rqst,
   input  logic [N_LIFTS*FLR_W-1:0]   car_floor,
   input  logic [N_LIFTS-1:0]         car_direction,
   input  logic [N_LIFTS-1:0]         car_motion,
   input  logic [N_LIFTS-1:0]         car_door_open,
   input  logic [N_LIFTS-1:0]         car_avail,
   output logic                       assign_valid,
   input  logic                       assign_ready,
   output logic [LIFT_W-1:0]          assign_car,
   output logic [FLR_W-1:0]           assign_floor,
   output logic                       assign_dir,
   output logic [N_FLOORS-1:0]        up_rqst_status,
   output logic [N_FLOORS-1:0]        dn_rqst_status
);

   localparam int N_SLOTS = 2 * N_FLOORS;
   localparam int SLOT_W  = $clog2(N_SLOTS);
   localparam int COST_W  = $clog2(2 * N_FLOORS) + 1;
   localparam int TMR_W   = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EVAL  = 2'd1;
   localparam logic [1:0] S_OFFER = 2'd2;

   localparam logic [1:0] SL_EMPTY = 2'd0;
   localparam logic [1:0] SL_PEND  = 2'd1;
   localparam logic [1:0] SL_ASSN  = 2'd2;

   // The top floor has no up button and the ground floor no down button.
   localparam logic [N_FLOORS-1:0] UP_MASK = ~(N_FLOORS'(1) << (N_FLOORS - 1));
   localparam logic [N_FLOORS-1:0] DN_MASK = ~N_FLOORS'(1);

   logic [1:0]          state_q;
   logic [SLOT_W-1:0]   ptr_q;
   logic [SLOT_W-1:0]   cur_slot_q;
   logic [LIFT_W-1:0]   eval_idx_q;
   logic [COST_W-1:0]   best_cost_q;
   logic                found_q;
   logic [LIFT_W-1:0]   assign_car_q;
   logic [FLR_W-1:0]    assign_floor_q;
   logic                assign_dir_q;

   logic [N_SLOTS-1:0]  btn_w;
   logic [N_SLOTS-1:0]  clr_w;
   logic [1:0]          slot_state_w [N_SLOTS];
   logic [FLR_W-1:0]    car_floor_a [N_LIFTS];
   logic                handshake_w;

   logic                scan_found;
   logic [SLOT_W-1:0]   scan_idx;
   logic [FLR_W-1:0]    scan_flr;
   logic                scan_dir;

   logic [FLR_W-1:0]    cf_w;
   logic [FLR_W-1:0]    dist_w;
   logic                away_w;
   logic [COST_W-1:0]   cost_w;
   logic                better_w;
   logic                last_car_w;
   logic [SLOT_W-1:0]   next_slot_w;

   assign btn_w = {dn_rqst & DN_MASK, up_rqst & UP_MASK};

   genvar gi, gc;
   generate
      for (gi = 0; gi < N_LIFTS; gi++) begin : g_cfl
         assign car_floor_a[gi] = car_floor[gi*FLR_W +: FLR_W];
      end

      for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
         localparam int   FLR = (gi < N_FLOORS) ? gi : gi - N_FLOORS;
         localparam logic DIR = (gi < N_FLOORS) ? 1'b1 : 1'b0;
         logic [N_LIFTS-1:0] hit;
         logic [1:0]         st_q;
         logic [LIFT_W-1:0]  car_q;
         logic [TMR_W-1:0]   tmr_q;

         // Any car stopped here with doors open, heading the slot's way, serves it.
         for (gc = 0; gc < N_LIFTS; gc++) begin : g_hit
            assign hit[gc] = car_door_open[gc] && (car_floor_a[gc] == FLR_W'(FLR)) &&
                             (car_direction[gc] == DIR);
         end
         assign clr_w[gi]        = |hit;
         assign slot_state_w[gi] = st_q;

         // Slot lifecycle: clear beats handshake beats press / timeout / drop-out.
         always_ff @(posedge clk) begin
            if (reset) begin
               st_q  <= SL_EMPTY;
               car_q <= '0;
               tmr_q <= '0;
            end else if (clr_w[gi]) begin
               st_q  <= SL_EMPTY;
               tmr_q <= '0;
            end else if (handshake_w && (cur_slot_q == SLOT_W'(gi))) begin
               st_q  <= SL_ASSN;
               car_q <= assign_car_q;
               tmr_q <= '0;
            end else begin
               case (st_q)
                  SL_EMPTY: if (btn_w[gi]) st_q <= SL_PEND;
                  SL_ASSN: begin
                     if (!car_avail[car_q] || (tmr_q == TMR_W'(TIMEOUT - 1))) begin
                        st_q  <= SL_PEND;
                        tmr_q <= '0;
                     end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end

         if (gi < N_FLOORS) begin : g_up
            assign up_rqst_status[gi] = (st_q != SL_EMPTY);
         end else begin : g_dn
            assign dn_rqst_status[gi-N_FLOORS] = (st_q != SL_EMPTY);
         end
      end
   endgenerate

   // Round-robin search for the first pending slot at or after the pointer.
   always_comb begin
      int idx;
      idx        = 0;
      scan_found = 1'b0;
      scan_idx   = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_SLOTS) idx = idx - N_SLOTS;
         if (!scan_found && (slot_state_w[SLOT_W'(idx)] == SL_PEND)) begin
            scan_found = 1'b1;
            scan_idx   = SLOT_W'(idx);
         end
      end
      if (scan_idx < SLOT_W'(N_FLOORS)) begin
         scan_flr = FLR_W'(scan_idx);
         scan_dir = 1'b1;
      end else begin
         scan_flr = FLR_W'(scan_idx - SLOT_W'(N_FLOORS));
         scan_dir = 1'b0;
      end
   end

   // Cost of the car under evaluation, using its live position and motion.
   always_comb begin
      cf_w = car_floor_a[eval_idx_q];
      if (cf_w > assign_floor_q) dist_w = cf_w - assign_floor_q;
      else                       dist_w = assign_floor_q - cf_w;
      away_w = car_motion[eval_idx_q] &&
               (( car_direction[eval_idx_q] && (assign_floor_q < cf_w)) ||
                (!car_direction[eval_idx_q] && (assign_floor_q > cf_w)));
      cost_w   = COST_W'(dist_w) + (away_w ? COST_W'(N_FLOORS) : COST_W'(0));
      better_w = car_avail[eval_idx_q] && (!found_q || (cost_w < best_cost_q));
   end

   assign last_car_w  = (eval_idx_q == LIFT_W'(N_LIFTS - 1));
   assign next_slot_w = (cur_slot_q == SLOT_W'(N_SLOTS - 1)) ? '0 : cur_slot_q + SLOT_W'(1);
   assign handshake_w = (state_q == S_OFFER) && assign_ready && !clr_w[cur_slot_q];

   // Dispatch FSM: pick a pending slot, score every car, offer the winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         ptr_q          <= '0;
         cur_slot_q     <= '0;
         eval_idx_q     <= '0;
         best_cost_q    <= '0;
         found_q        <= 1'b0;
         assign_car_q   <= '0;
         assign_floor_q <= '0;
         assign_dir_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (scan_found) begin
                  cur_slot_q     <= scan_idx;
                  assign_floor_q <= scan_flr;
                  assign_dir_q   <= scan_dir;
                  eval_idx_q     <= '0;
                  found_q        <= 1'b0;
                  state_q        <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (clr_w[cur_slot_q] || (slot_state_w[cur_slot_q] != SL_PEND)) begin
                  // Served while being scored: nothing left to offer.
                  state_q <= S_IDLE;
               end else begin
                  if (better_w) begin
                     best_cost_q  <= cost_w;
                     assign_car_q <= eval_idx_q;
                  end
                  found_q <= found_q | car_avail[eval_idx_q];
                  if (last_car_w) begin
                     if (found_q || car_avail[eval_idx_q]) begin
                        state_q <= S_OFFER;
                     end else begin
                        state_q <= S_IDLE;
                        ptr_q   <= next_slot_w;
                     end
                  end else begin
                     eval_idx_q <= eval_idx_q + LIFT_W'(1);
                  end
               end
            end
            S_OFFER: begin
               if (clr_w[cur_slot_q] || (slot_state_w[cur_slot_q] != SL_PEND)) begin
                  state_q <= S_IDLE;
               end else if (assign_ready) begin
                  state_q <= S_IDLE;
                  ptr_q   <= next_slot_w;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign assign_valid = (state_q == S_OFFER);
   assign assign_car   = assign_car_q;
   assign assign_floor = assign_floor_q;
   assign assign_dir   = assign_dir_q;

endmodule

// File: tb/tb_lift_hall_dispatcher.sv
// Scenario bench for the hall dispatcher: expected offers are queued when a
// request is driven and compared when the dispatcher raises assign_valid.
module tb_lift_hall_dispatcher;

   localparam int NF = 12;
   localparam int NL = 3;
   localparam int TO = 64;
   localparam int FW = 4;
   localparam int LW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NF-1:0]     up_rqst = '0;
   logic [NF-1:0]     dn_rqst = '0;
   logic [NL*FW-1:0]  car_floor = '0;
   logic [NL-1:0]     car_direction = '0;
   logic [NL-1:0]     car_motion = '0;
   logic [NL-1:0]     car_door_open = '0;
   logic [NL-1:0]     car_avail = '0;
   logic              assign_ready = 1'b0;
   logic              assign_valid;
   logic [LW-1:0]     assign_car;
   logic [FW-1:0]     assign_floor;
   logic              assign_dir;
   logic [NF-1:0]     up_rqst_status;
   logic [NF-1:0]     dn_rqst_status;

   typedef struct packed {
      logic [LW-1:0] car;
      logic [FW-1:0] flr;
      logic          dir;
   } asg_t;

   asg_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   lift_hall_dispatcher #(.N_FLOORS(NF), .N_LIFTS(NL), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .up_rqst(up_rqst), .dn_rqst(dn_rqst),
      .car_floor(car_floor), .car_direction(car_direction), .car_motion(car_motion),
      .car_door_open(car_door_open), .car_avail(car_avail),
      .assign_valid(assign_valid), .assign_ready(assign_ready),
      .assign_car(assign_car), .assign_floor(assign_floor), .assign_dir(assign_dir),
      .up_rqst_status(up_rqst_status), .dn_rqst_status(dn_rqst_status)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; up_rqst = '0; dn_rqst = '0; assign_ready = 1'b0; car_door_open = '0;
      tick(); tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic set_car(input int c, input int flr, input bit dir, input bit mov, input bit av);
      car_floor[c*FW +: FW] = FW'(flr);
      car_direction[c] = dir;
      car_motion[c]    = mov;
      car_avail[c]     = av;
   endtask

   task automatic cars_spread();
      set_car(0, 0, 1'b1, 1'b0, 1'b1);
      set_car(1, 5, 1'b1, 1'b0, 1'b1);
      set_car(2, 11, 1'b0, 1'b0, 1'b1);
   endtask

   // Hold the button across exactly one sampling edge.
   task automatic press(input bit up, input int f);
      if (up) up_rqst[f] = 1'b1; else dn_rqst[f] = 1'b1;
      tick();
      up_rqst = '0; dn_rqst = '0;
   endtask

   task automatic wait_valid(input int budget, output int cycles, output bit got);
      got = 1'b0; cycles = 0;
      for (int i = 0; i < budget; i++) begin
         if (assign_valid) begin
            got = 1'b1; cycles = i;
            return;
         end
         tick();
      end
      if (assign_valid) begin got = 1'b1; cycles = budget; end
   endtask

   task automatic take_offer(output asg_t e, output asg_t a);
      a = '{car: assign_car, flr: assign_floor, dir: assign_dir};
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
      $display("offer car=%0d floor=%0d dir=%0d", assign_car, assign_floor, assign_dir);
   endtask

   task automatic handshake();
      assign_ready = 1'b1;
      tick();
      assign_ready = 1'b0;
   endtask

   task automatic test_reset();
      set_car(0, 0, 1'b1, 1'b0, 1'b0);
      set_car(1, 5, 1'b1, 1'b0, 1'b0);
      set_car(2, 11, 1'b0, 1'b0, 1'b0);
      reset = 1'b1; up_rqst = '1; dn_rqst = '1;
      tick(); tick();
      n_checks++;
      if (up_rqst_status !== '0) begin n_fail++; $display("FAIL reset_up_lamps: got %h expected 000", up_rqst_status); end
      n_checks++;
      if (dn_rqst_status !== '0) begin n_fail++; $display("FAIL reset_dn_lamps: got %h expected 000", dn_rqst_status); end
      n_checks++;
      if (assign_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", assign_valid); end
      n_checks++;
      if ({assign_car, assign_floor, assign_dir} !== '0) begin
         n_fail++; $display("FAIL reset_assign_bus: got %h expected 0", {assign_car, assign_floor, assign_dir});
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (up_rqst_status !== 12'h7FF) begin n_fail++; $display("FAIL release_up_lamps: got %h expected 7ff", up_rqst_status); end
      n_checks++;
      if (dn_rqst_status !== 12'hFFE) begin n_fail++; $display("FAIL release_dn_lamps: got %h expected ffe", dn_rqst_status); end
      up_rqst = '0; dn_rqst = '0;
   endtask

   task automatic test_nearest();
      int cyc; bit got; asg_t e, a;
      do_reset(); cars_spread();
      exp_q.push_back('{car: 2'd1, flr: 4'd6, dir: 1'b1});
      press(1'b1, 6);
      wait_valid(20, cyc, got);
      n_checks++;
      if (!got || cyc != NL + 1) begin n_fail++; $display("FAIL nearest_latency: got valid=%0d after %0d edges expected 1 after %0d", got, cyc, NL + 1); end
      take_offer(e, a);
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL nearest_offer: got %h expected %h", a, e); end
      handshake();
      n_checks++;
      if (assign_valid !== 1'b0) begin n_fail++; $display("FAIL nearest_valid_drop: got %b expected 0", assign_valid); end
      n_checks++;
      if (up_rqst_status[6] !== 1'b1) begin n_fail++; $display("FAIL nearest_lamp_kept: got %b expected 1", up_rqst_status[6]); end
   endtask

   task automatic test_tie_direction();
      int cyc; bit got; asg_t e, a;
      do_reset();
      set_car(0, 4, 1'b1, 1'b0, 1'b1);
      set_car(1, 8, 1'b0, 1'b0, 1'b1);
      set_car(2, 0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back('{car: 2'd0, flr: 4'd6, dir: 1'b0});
      press(1'b0, 6);
      wait_valid(20, cyc, got);
      take_offer(e, a);
      n_checks++;
      if (!got || a !== e) begin n_fail++; $display("FAIL tie_lowest_index: valid=%0d got %h expected %h", got, a, e); end
      handshake();

      do_reset();
      set_car(0, 5, 1'b0, 1'b1, 1'b1);
      set_car(1, 9, 1'b0, 1'b0, 1'b1);
      set_car(2, 0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back('{car: 2'd1, flr: 4'd6, dir: 1'b1});
      press(1'b1, 6);
      wait_valid(20, cyc, got);
      take_offer(e, a);
      n_checks++;
      if (!got || a !== e) begin n_fail++; $display("FAIL direction_penalty: valid=%0d got %h expected %h", got, a, e); end
      handshake();
   endtask

   task automatic test_no_car();
      int cyc; bit got; asg_t e, a;
      do_reset();
      set_car(0, 0, 1'b1, 1'b0, 1'b0);
      set_car(1, 5, 1'b1, 1'b0, 1'b0);
      set_car(2, 7, 1'b0, 1'b0, 1'b0);
      press(1'b1, 2);
      wait_valid(30, cyc, got);
      n_checks++;
      if (got !== 1'b0) begin n_fail++; $display("FAIL nocar_no_offer: got valid after %0d edges expected none", cyc); end
      n_checks++;
      if (up_rqst_status[2] !== 1'b1) begin n_fail++; $display("FAIL nocar_lamp: got %b expected 1", up_rqst_status[2]); end
      car_avail[2] = 1'b1;
      exp_q.push_back('{car: 2'd2, flr: 4'd2, dir: 1'b1});
      wait_valid(2 * NF * (NL + 2) + 10, cyc, got);
      take_offer(e, a);
      n_checks++;
      if (!got || a !== e) begin n_fail++; $display("FAIL nocar_late_offer: valid=%0d got %h expected %h", got, a, e); end
      handshake();
   endtask

   task automatic test_timeout();
      int cyc; bit got; asg_t e, a;
      do_reset(); cars_spread();
      exp_q.push_back('{car: 2'd1, flr: 4'd6, dir: 1'b1});
      press(1'b1, 6);
      wait_valid(20, cyc, got);
      take_offer(e, a);
      n_checks++;
      if (!got || a !== e) begin n_fail++; $display("FAIL timeout_first_offer: valid=%0d got %h expected %h", got, a, e); end
      handshake();
      wait_valid(56, cyc, got);
      n_checks++;
      if (got !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got re-offer after %0d edges expected none before 56", cyc); end
      n_checks++;
      if (up_rqst_status[6] !== 1'b1) begin n_fail++; $display("FAIL timeout_lamp: got %b expected 1", up_rqst_status[6]); end
      exp_q.push_back('{car: 2'd1, flr: 4'd6, dir: 1'b1});
      wait_valid(40, cyc, got);
      n_checks++;
      if (!got || (56 + cyc) < TO || (56 + cyc) > TO + NL + 3) begin
         n_fail++; $display("FAIL timeout_reoffer_time: valid=%0d after %0d edges expected %0d..%0d", got, 56 + cyc, TO, TO + NL + 3);
      end
      take_offer(e, a);
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL timeout_reoffer: got %h expected %h", a, e); end
      handshake();
   endtask

   task automatic test_dropout();
      int cyc; bit got; asg_t e, a;
      do_reset(); cars_spread();
      exp_q.push_back('{car: 2'd1, flr: 4'd6, dir: 1'b1});
      press(1'b1, 6);
      wait_valid(20, cyc, got);
      take_offer(e, a);
      n_checks++;
      if (!got || a !== e) begin n_fail++; $display("FAIL dropout_first_offer: valid=%0d got %h expected %h", got, a, e); end
      handshake();
      tick(); tick(); tick();
      car_avail[1] = 1'b0;
      tick();
      exp_q.push_back('{car: 2'd2, flr: 4'd6, dir: 1'b1});
      wait_valid(20, cyc, got);
      n_checks++;
      if (!got || cyc != NL + 1) begin n_fail++; $display("FAIL dropout_latency: valid=%0d after %0d edges expected %0d", got, cyc, NL + 1); end
      take_offer(e, a);
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL dropout_reoffer: got %h expected %h", a, e); end
      handshake();
   endtask

   task automatic test_clear();
      int cyc; bit got; asg_t e, a;
      do_reset(); cars_spread();
      exp_q.push_back('{car: 2'd1, flr: 4'd6, dir: 1'b1});
      press(1'b1, 6);
      wait_valid(20, cyc, got);
      take_offer(e, a);
      n_checks++;
      if (!got || a !== e) begin n_fail++; $display("FAIL clear_setup_offer: valid=%0d got %h expected %h", got, a, e); end
      handshake();
      set_car(1, 6, 1'b1, 1'b0, 1'b1);
      car_door_open[1] = 1'b1;
      up_rqst[6] = 1'b1;
      tick();
      n_checks++;
      if (up_rqst_status[6] !== 1'b0) begin n_fail++; $display("FAIL clear_lamp: got %b expected 0", up_rqst_status[6]); end
      car_door_open[1] = 1'b0; up_rqst[6] = 1'b0;
      set_car(1, 5, 1'b1, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (up_rqst_status[6] !== 1'b0) begin n_fail++; $display("FAIL clear_press_ignored: got %b expected 0", up_rqst_status[6]); end

      do_reset(); cars_spread();
      exp_q.push_back('{car: 2'd1, flr: 4'd6, dir: 1'b1});
      press(1'b1, 6);
      wait_valid(20, cyc, got);
      take_offer(e, a);
      n_checks++;
      if (!got || a !== e) begin n_fail++; $display("FAIL withdraw_setup_offer: valid=%0d got %h expected %h", got, a, e); end
      assign_ready = 1'b1;
      set_car(0, 6, 1'b1, 1'b0, 1'b1);
      car_door_open[0] = 1'b1;
      tick();
      n_checks++;
      if (assign_valid !== 1'b0) begin n_fail++; $display("FAIL withdraw_valid: got %b expected 0", assign_valid); end
      n_checks++;
      if (up_rqst_status[6] !== 1'b0) begin n_fail++; $display("FAIL withdraw_lamp: got %b expected 0", up_rqst_status[6]); end
      assign_ready = 1'b0; car_door_open[0] = 1'b0;
      set_car(0, 0, 1'b1, 1'b0, 1'b1);
      wait_valid(15, cyc, got);
      n_checks++;
      if (got !== 1'b0) begin n_fail++; $display("FAIL withdraw_no_reoffer: got valid after %0d edges expected none", cyc); end
   endtask

   task automatic test_back_to_back();
      int cyc; bit got; asg_t e, a;
      do_reset(); cars_spread();
      exp_q.push_back('{car: 2'd0, flr: 4'd1, dir: 1'b1});
      exp_q.push_back('{car: 2'd2, flr: 4'd10, dir: 1'b0});
      up_rqst[1] = 1'b1; dn_rqst[10] = 1'b1;
      tick();
      up_rqst = '0; dn_rqst = '0;
      for (int n = 0; n < 2; n++) begin
         wait_valid(30, cyc, got);
         take_offer(e, a);
         n_checks++;
         if (!got || a !== e) begin n_fail++; $display("FAIL b2b_offer%0d: valid=%0d got %h expected %h", n, got, a, e); end
         handshake();
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue: got %0d left expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_nearest();
      test_tie_direction();
      test_no_car();
      test_timeout();
      test_dropout();
      test_clear();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
